// File: rtl/smu_cfg_pkg.sv
// Shared types and CRC-8 helpers for the SMU configuration bitstream loader.
package smu_cfg_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CRC   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } cfg_load_state_t;

    localparam int         CRC_W    = 8;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    // One serial CRC-8 step, non-reflected, MSB of the register is the feedback tap.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       din,
                                             input logic [7:0] poly = CRC_POLY);
        logic fb;
        fb = crc[7] ^ din;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/smu_crc_lanes.sv
// Combinational CRC-8 update over one LANES-wide beat, data[LANES-1] processed first.
module smu_crc_lanes
    import smu_cfg_pkg::*;
#(
    parameter int         LANES = 4,
    parameter logic [7:0] POLY  = 8'h07
)(
    input  logic [7:0]       crc_in,
    input  logic [LANES-1:0] data,
    output logic [7:0]       crc_out
);

    logic [7:0] crc_s;

    // Unrolled serial update across the beat in stream order.
    always_comb begin
        crc_s = crc_in;
        for (int i = LANES - 1; i >= 0; i--) begin
            crc_s = crc8_step(crc_s, data[i], POLY);
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/smu_bitstream_loader.sv
// Multi-lane config bitstream loader: deserializes payload into a shadow register and
// commits it to ParallelOut only when the trailing CRC-8 matches.
module smu_bitstream_loader
    import smu_cfg_pkg::*;
#(
    parameter int         CFG_SIZE = 100,
    parameter int         LANES    = 4,
    parameter int         CRC_W    = 8,
    parameter logic [7:0] CRC_POLY = 8'h07
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    StreamData,
    input  logic                StreamValid,
    output logic                StreamReady,
    input  logic                CfgClear,
    output logic [CFG_SIZE-1:0] ParallelOut,
    output logic                CfgBusy,
    output logic                CfgDone,
    output logic                CfgError
);

    localparam int BEATS     = (CFG_SIZE + LANES - 1) / LANES;
    localparam int SHW       = BEATS * LANES;
    localparam int CRC_BEATS = (CRC_W + LANES - 1) / LANES;
    localparam int CNT_W     = $clog2(BEATS + 1);
    localparam int TCNT_W    = $clog2(CRC_BEATS + 1);
    localparam int RXR_W     = (LANES < CRC_W) ? (CRC_W - LANES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [TCNT_W-1:0] LAST_TBEAT = TCNT_W'(CRC_BEATS - 1);

    cfg_load_state_t     state_r, state_n;
    logic [CNT_W-1:0]    count_r, count_n;
    logic [TCNT_W-1:0]   tcnt_r, tcnt_n;
    logic [SHW-1:0]      shadow_r, shadow_n, shadow_shift_s;
    logic [7:0]          crc_r, crc_n, crc_upd_s;
    logic [RXR_W-1:0]    rx_r, rx_n, rx_keep_s;
    logic [CRC_W-1:0]    rx_full_s;
    logic [CFG_SIZE-1:0] pout_r, pout_n;
    logic                done_r, done_n;
    logic                err_r, err_n;

    smu_crc_lanes #(
        .LANES (LANES),
        .POLY  (CRC_POLY)
    ) u_crc (
        .crc_in  (crc_r),
        .data    (StreamData),
        .crc_out (crc_upd_s)
    );

    generate
        if (SHW > LANES) begin : g_shadow_multi
            assign shadow_shift_s = {shadow_r[SHW-LANES-1:0], StreamData};
        end else begin : g_shadow_single
            assign shadow_shift_s = StreamData;
        end
        // Only the bits still needed for the final compare are kept between trailer beats.
        if (LANES < CRC_W) begin : g_rx_narrow
            assign rx_full_s = {rx_r, StreamData};
            assign rx_keep_s = rx_full_s[RXR_W-1:0];
        end else begin : g_rx_wide
            assign rx_full_s = StreamData[CRC_W-1:0];
            assign rx_keep_s = '0;
        end
    endgenerate

    assign StreamReady = ((state_r == LOAD) || (state_r == CRC)) && !CfgClear;
    assign CfgBusy     = ((state_r == LOAD) && (count_r != '0)) || (state_r == CRC);
    assign ParallelOut = pout_r;
    assign CfgDone     = done_r;
    assign CfgError    = err_r;

    // Next-state and datapath update; CfgClear takes priority over any offered beat.
    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        tcnt_n   = tcnt_r;
        shadow_n = shadow_r;
        crc_n    = crc_r;
        rx_n     = rx_r;
        pout_n   = pout_r;
        done_n   = done_r;
        err_n    = err_r;
        if (CfgClear) begin
            state_n  = LOAD;
            count_n  = '0;
            tcnt_n   = '0;
            shadow_n = '0;
            crc_n    = CRC_INIT;
            rx_n     = '0;
            if (state_r == ERROR) begin
                err_n = 1'b0;
            end else begin
                err_n = err_r;
            end
        end else if (StreamValid) begin
            case (state_r)
                LOAD: begin
                    shadow_n = shadow_shift_s;
                    crc_n    = crc_upd_s;
                    if (count_r == '0) begin
                        done_n = 1'b0;
                    end else begin
                        done_n = done_r;
                    end
                    if (count_r == LAST_BEAT) begin
                        count_n = '0;
                        state_n = CRC;
                    end else begin
                        count_n = count_r + CNT_W'(1);
                    end
                end
                CRC: begin
                    rx_n = rx_keep_s;
                    if (tcnt_r == LAST_TBEAT) begin
                        tcnt_n = '0;
                        if (rx_full_s == crc_r[CRC_W-1:0]) begin
                            state_n = DONE;
                            pout_n  = shadow_r[CFG_SIZE-1:0];
                            done_n  = 1'b1;
                            err_n   = 1'b0;
                        end else begin
                            state_n = ERROR;
                            done_n  = 1'b0;
                            err_n   = 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt_r + TCNT_W'(1);
                    end
                end
                DONE:    state_n = DONE;
                ERROR:   state_n = ERROR;
                default: state_n = LOAD;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Loader state, counters, shadow, CRC and committed configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= LOAD;
            count_r  <= '0;
            tcnt_r   <= '0;
            shadow_r <= '0;
            crc_r    <= CRC_INIT;
            rx_r     <= '0;
            pout_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            count_r  <= count_n;
            tcnt_r   <= tcnt_n;
            shadow_r <= shadow_n;
            crc_r    <= crc_n;
            rx_r     <= rx_n;
            pout_r   <= pout_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end

endmodule
